// File: rtl/rr_priority_arbiter_pkg.sv
// Shared types and helpers for the round-robin / fixed-priority arbiter.
package rr_arb_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_t;

  // Ceiling log2 for parameter elaboration; clog2(1) = 0
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_arbiter_pick.sv
// Combinational rotating priority picker: rotate req so ptr lands on the
// top index, take the highest set bit, then map it back to a real index.
module rr_priority_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   win,
  output logic [IDW-1:0] win_id,
  output logic           found
);

  localparam int unsigned NU = N;

  logic [N-1:0] rot;
  int unsigned  src;
  int unsigned  j_win;

  // Rotate, highest-index encode, un-rotate
  always_comb begin
    rot    = '0;
    j_win  = 0;
    found  = 1'b0;
    win    = '0;
    win_id = '0;
    src    = 0;
    for (int unsigned j = 0; j < NU; j++) begin
      src = j + 32'(ptr) + 1;
      if (src >= NU) src = src - NU;
      rot[j] = req[IDW'(src)];
    end
    for (int unsigned j = 0; j < NU; j++) begin
      if (rot[j]) begin
        found = 1'b1;
        j_win = j;
      end
    end
    src = j_win + 32'(ptr) + 1;
    if (src >= NU) src = src - NU;
    if (found) begin
      win[IDW'(src)] = 1'b1;
      win_id         = IDW'(src);
    end
  end

endmodule

// File: rtl/rr_priority_arbiter.sv
// Registered-grant arbiter with fixed/round-robin modes and a hold limit.
module rr_priority_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int IDW      = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           rr_en,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid
);

  localparam int unsigned HW_RAW = clog2(32'(MAX_HOLD) + 1);
  localparam int unsigned HW     = (HW_RAW < 1) ? 1 : HW_RAW;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] pick_ptr;
  logic [HW-1:0]  hold_cnt;
  logic           owner_req;
  logic           timeout;
  logic [N-1:0]   arb_req;
  logic [N-1:0]   win;
  logic [IDW-1:0] win_id;
  logic           found;

  // Index just below w (wrapping), so w becomes lowest priority next time
  function automatic logic [IDW-1:0] prev_id(input logic [IDW-1:0] w);
    return (w == '0) ? IDW'(N - 1) : (w - IDW'(1));
  endfunction

  // Owner status, timeout detection and arbitration inputs
  always_comb begin
    owner_req = |(req & gnt);
    timeout   = (state == ST_GRANT) && owner_req && (MAX_HOLD != 0) &&
                (hold_cnt == HW'(MAX_HOLD));
    arb_req   = timeout ? (req & ~gnt) : req;
    pick_ptr  = rr_en ? ptr : IDW'(N - 1);
  end

  rr_priority_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req    (arb_req),
    .ptr    (pick_ptr),
    .win    (win),
    .win_id (win_id),
    .found  (found)
  );

  // Grant FSM, rotation pointer, hold counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      ptr       <= IDW'(N - 1);
      hold_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            state     <= ST_GRANT;
            gnt       <= win;
            gnt_id    <= win_id;
            gnt_valid <= 1'b1;
            hold_cnt  <= HW'(1);
            ptr       <= prev_id(win_id);
          end
        end
        ST_GRANT: begin
          if (owner_req && !timeout) begin
            if (MAX_HOLD != 0) hold_cnt <= hold_cnt + HW'(1);
          end else if (found) begin
            gnt       <= win;
            gnt_id    <= win_id;
            gnt_valid <= 1'b1;
            hold_cnt  <= HW'(1);
            ptr       <= prev_id(win_id);
          end else if (owner_req) begin
            // Timed out with nobody else waiting: re-grant the owner in place
            hold_cnt  <= HW'(1);
            ptr       <= prev_id(gnt_id);
          end else begin
            state     <= ST_IDLE;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            hold_cnt  <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Directed + randomized bench for rr_priority_arbiter with a reference model.
module tb_rr_priority_arbiter;

  localparam int N  = 4;
  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       rr_en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] id;
    logic       v;
  } out_t;

  out_t sb[$];

  logic [3:0] m_gnt;
  int         m_ptr;
  int         m_hold;

  rr_priority_arbiter #(
    .N        (4),
    .IDW      (2),
    .MAX_HOLD (MH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .rr_en     (rr_en),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  always #5 clk = ~clk;

  // Search start, start-1, ... wrapping; -1 if nothing requested
  function automatic int arb(input logic [3:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (start - k + N) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int owner(input logic [3:0] g);
    for (int k = 0; k < N; k++) if (g[k]) return k;
    return -1;
  endfunction

  task automatic give(input int w);
    m_gnt  = 4'b0001 << w;
    m_hold = 1;
    m_ptr  = (w + N - 1) % N;
  endtask

  task automatic model(input logic r_rst, input logic [3:0] r_req, input logic r_rr);
    int start;
    int k;
    int w;
    start = r_rr ? m_ptr : N - 1;
    if (r_rst) begin
      m_gnt  = 4'b0000;
      m_ptr  = N - 1;
      m_hold = 0;
    end else if (m_gnt == 4'b0000) begin
      w = arb(r_req, start);
      if (w >= 0) give(w);
    end else begin
      k = owner(m_gnt);
      if (r_req[k] && m_hold < MH) begin
        m_hold = m_hold + 1;
      end else if (!r_req[k]) begin
        w = arb(r_req, start);
        if (w >= 0) give(w);
        else begin
          m_gnt  = 4'b0000;
          m_hold = 0;
        end
      end else begin
        w = arb(r_req & ~m_gnt, start);
        if (w >= 0) give(w);
        else give(k);
      end
    end
  endtask

  task automatic step(input logic s_rst, input logic [3:0] s_req, input logic s_rr,
                      input string tag);
    out_t e;
    out_t got;
    int   o;
    @(negedge clk);
    rst   = s_rst;
    req   = s_req;
    rr_en = s_rr;
    model(s_rst, s_req, s_rr);
    o     = owner(m_gnt);
    e.g   = m_gnt;
    e.id  = (o < 0) ? 2'd0 : 2'(o);
    e.v   = (m_gnt != 4'b0000);
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = {gnt, gnt_id, gnt_valid};
    e   = sb.pop_front();
    checks++;
    assert (got === e) else begin
      errors++;
      $error("FAIL %s got gnt/id/v=%b exp %b", tag, got, e);
    end
  endtask

  task automatic dchk(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {gnt, gnt_id, gnt_valid};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got gnt/id/v=%b exp %b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] eid;
    logic [3:0] eg;
    logic [3:0] rq;
    logic       rr;
    logic       rs;

    rst    = 1'b1;
    req    = 4'b0000;
    rr_en  = 1'b0;
    m_gnt  = 4'b0000;
    m_ptr  = N - 1;
    m_hold = 0;

    // 1: reset with all requests up, first grant after release
    step(1'b1, 4'b1111, 1'b0, "rst0");
    dchk("rst0_zero", 7'b0000_00_0);
    step(1'b1, 4'b1111, 1'b0, "rst1");
    dchk("rst1_zero", 7'b0000_00_0);
    step(1'b0, 4'b1111, 1'b0, "first");
    dchk("first_gnt3", 7'b1000_11_1);

    // 2: fixed mode timeout alternation between 2 and 0
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 4'b0101, 1'b0, "fix");
      eg = (i < 4 || i >= 8) ? 4'b0100 : 4'b0001;
      dchk("fix_seq", (i < 4 || i >= 8) ? {eg, 2'd2, 1'b1} : {eg, 2'd0, 1'b1});
    end

    // 3: round-robin rotation 3,2,1,0,3 each held 4 cycles
    step(1'b1, 4'b0000, 1'b1, "rr_rst");
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 4'b1111, 1'b1, "rr");
      eid = 2'(3 - ((i / 4) % 4));
      eg  = 4'b0001 << eid;
      dchk("rr_seq", {eg, eid, 1'b1});
    end

    // 4: owner 2 releases while req[0] waits: handover without gap
    step(1'b1, 4'b0000, 1'b0, "h_rst");
    step(1'b0, 4'b0101, 1'b0, "h_own");
    dchk("h_own2", 7'b0100_10_1);
    step(1'b0, 4'b0001, 1'b0, "h_rel");
    dchk("h_to0", 7'b0001_00_1);

    // 5: lone requester keeps grant across timeouts, then drops
    step(1'b0, 4'b0000, 1'b0, "idle");
    dchk("idle_zero", 7'b0000_00_0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 4'b0010, 1'b0, "solo");
      dchk("solo_gnt1", 7'b0010_01_1);
    end
    step(1'b0, 4'b0000, 1'b0, "solo_end");
    dchk("solo_drop", 7'b0000_00_0);

    // 6: reset mid-grant, grant returns one cycle after release
    step(1'b0, 4'b1000, 1'b0, "r6a");
    step(1'b0, 4'b1000, 1'b0, "r6b");
    dchk("r6_held", 7'b1000_11_1);
    step(1'b1, 4'b1000, 1'b0, "r6_rst");
    dchk("r6_drop", 7'b0000_00_0);
    step(1'b0, 4'b1000, 1'b0, "r6_back");
    dchk("r6_back3", 7'b1000_11_1);

    // Randomized mix of modes, sticky requests and occasional reset
    rq = 4'b0000;
    rr = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 2) == 0) rq = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) rr = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 29) == 0);
      step(rs, rq, rr, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
